ac_modulation_demod: RTL and testbench

- Receive-side counterpart of the AC motor control modulator. Takes the single-bit `modulation` PWM stream and recovers, per fixed measurement window, the local duty value as a 12-bit sample.
- Recovers the fundamental (sine) period and peak amplitude from the sample stream, for closed-loop checking of commanded frequency/amplitude.
- Sits between the modulator output (or an isolated feedback pin) and the supervisory logic.

---
 rtl/ac_modulation_demod.sv | 193 +++++++++++++++++++
 tb/tb_ac_modulation_demod.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ac_modulation_demod.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ac_modulation_demod: windowed PWM duty recovery plus fundamental          |
// | period/amplitude tracking.                        Revision: 1.0          |
// +--------------------------------------------------------------------------+
module ac_modulation_demod #(
    parameter int WINDOW_LOG2 = 12,
    parameter int HYST        = 64,
    parameter int PERIOD_W    = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   modulation,
    output logic [11:0]            duty,
    output logic                   duty_valid,
    output logic [WINDOW_LOG2-1:0] carrier_edges,
    output logic [PERIOD_W-1:0]    fund_period,
    output logic [11:0]            amplitude,
    output logic                   fund_valid,
    output logic                   stall
);
    localparam int                  W         = WINDOW_LOG2;
    localparam logic [W-1:0]        C_WIN_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] C_PER_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] C_PER_MAX = '1;
    localparam logic [11:0]         C_UP_TH   = 12'(2048 + HYST);
    localparam logic [11:0]         C_DN_TH   = 12'(2048 - HYST);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } xstate_e;

    logic                sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]          start_q, start_d;
    logic [W-1:0]        win_cnt_q, win_cnt_d, edge_cnt_q, edge_cnt_d;
    logic [W:0]          high_cnt_q, high_cnt_d;
    logic [11:0]         duty_q, duty_d;
    logic                duty_valid_q, duty_valid_d;
    logic [W-1:0]        edges_q, edges_d;
    xstate_e             state_q, state_d;
    logic                armed_q, armed_d;
    logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d, fund_period_q, fund_period_d;
    logic [11:0]         min_q, min_d, max_q, max_d, amplitude_q, amplitude_d;
    logic                fund_valid_q, fund_valid_d, stall_q, stall_d;

    logic [W:0]   w_high_sum;
    logic [W-1:0] w_edge_sum;
    logic [11:0]  w_scaled, w_amp_diff;
    logic         w_rise, w_active, w_terminal, w_crossing;

    assign w_high_sum = high_cnt_q + {{W{1'b0}}, sync2_q};

    generate
        if (W >= 12) begin : g_scale_down
            assign w_scaled = w_high_sum[W-1 -: 12];
        end else begin : g_scale_up
            assign w_scaled = {w_high_sum[W-1:0], {(12-W){1'b0}}};
        end
    endgenerate

    always_comb begin
        sync1_d    = modulation;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        w_rise     = sync2_q & ~prev_q;
        // Window start is held off by the synchronizer depth so the first
        // window only ever sees post-reset samples.
        w_active   = (start_q == 2'd2);
        start_d    = w_active ? start_q : start_q + 2'd1;
        w_terminal = w_active && (win_cnt_q == '1);
        w_edge_sum = (edge_cnt_q == '1) ? edge_cnt_q
                                        : edge_cnt_q + {{(W-1){1'b0}}, w_rise};

        win_cnt_d    = w_active ? win_cnt_q + C_WIN_ONE : win_cnt_q;
        high_cnt_d   = high_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        duty_d       = duty_q;
        edges_d      = edges_q;
        duty_valid_d = w_terminal;
        if (w_active) begin
            high_cnt_d = w_terminal ? '0 : w_high_sum;
            edge_cnt_d = w_terminal ? '0 : w_edge_sum;
        end
        if (w_terminal) begin
            duty_d  = w_high_sum[W] ? 12'hFFF : w_scaled;
            edges_d = w_edge_sum;
        end

        state_d    = state_q;
        w_crossing = 1'b0;
        if (duty_valid_q) begin
            case (state_q)
                ST_INIT: begin
                    if (duty_q > C_UP_TH)      state_d = ST_HIGH;
                    else if (duty_q < C_DN_TH) state_d = ST_LOW;
                end
                ST_LOW: begin
                    if (duty_q > C_UP_TH) begin
                        state_d    = ST_HIGH;
                        w_crossing = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (duty_q < C_DN_TH) state_d = ST_LOW;
                end
                default: state_d = ST_INIT;
            endcase
        end

        armed_d       = armed_q;
        per_cnt_d     = per_cnt_q;
        min_d         = min_q;
        max_d         = max_q;
        fund_period_d = fund_period_q;
        amplitude_d   = amplitude_q;
        fund_valid_d  = 1'b0;
        w_amp_diff    = max_q - min_q;
        if (duty_valid_q) begin
            if (w_crossing) begin
                armed_d   = 1'b1;
                per_cnt_d = C_PER_ONE;
                min_d     = duty_q;
                max_d     = duty_q;
                if (armed_q) begin
                    fund_valid_d  = 1'b1;
                    fund_period_d = per_cnt_q;
                    amplitude_d   = {1'b0, w_amp_diff[11:1]};
                end
            end else begin
                per_cnt_d = (per_cnt_q == C_PER_MAX) ? per_cnt_q : per_cnt_q + C_PER_ONE;
                if (duty_q < min_q) min_d = duty_q;
                if (duty_q > max_q) max_d = duty_q;
            end
        end
        stall_d = (per_cnt_d == C_PER_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
            start_q       <= 2'd0;
            win_cnt_q     <= '0;
            high_cnt_q    <= '0;
            edge_cnt_q    <= '0;
            duty_q        <= '0;
            duty_valid_q  <= 1'b0;
            edges_q       <= '0;
            state_q       <= ST_INIT;
            armed_q       <= 1'b0;
            per_cnt_q     <= '0;
            min_q         <= '0;
            max_q         <= '0;
            fund_period_q <= '0;
            amplitude_q   <= '0;
            fund_valid_q  <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            start_q       <= start_d;
            win_cnt_q     <= win_cnt_d;
            high_cnt_q    <= high_cnt_d;
            edge_cnt_q    <= edge_cnt_d;
            duty_q        <= duty_d;
            duty_valid_q  <= duty_valid_d;
            edges_q       <= edges_d;
            state_q       <= state_d;
            armed_q       <= armed_d;
            per_cnt_q     <= per_cnt_d;
            min_q         <= min_d;
            max_q         <= max_d;
            fund_period_q <= fund_period_d;
            amplitude_q   <= amplitude_d;
            fund_valid_q  <= fund_valid_d;
            stall_q       <= stall_d;
        end
    end

    assign duty          = duty_q;
    assign duty_valid    = duty_valid_q;
    assign carrier_edges = edges_q;
    assign fund_period   = fund_period_q;
    assign amplitude     = amplitude_q;
    assign fund_valid    = fund_valid_q;
    assign stall         = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_ac_modulation_demod.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ac_modulation_demod: window-table stimulus with a duty scoreboard.     |
// |                                                   Revision: 1.0          |
// +--------------------------------------------------------------------------+
module tb_ac_modulation_demod;
    localparam int W    = 8;
    localparam int PW   = 5;
    localparam int HYST = 64;
    localparam int WIN  = 1 << W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          modulation;
    logic [11:0]   duty, amplitude;
    logic          duty_valid, fund_valid, stall;
    logic [W-1:0]  carrier_edges;
    logic [PW-1:0] fund_period;

    ac_modulation_demod #(.WINDOW_LOG2(W), .HYST(HYST), .PERIOD_W(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .modulation   (modulation),
        .duty         (duty),
        .duty_valid   (duty_valid),
        .carrier_edges(carrier_edges),
        .fund_period  (fund_period),
        .amplitude    (amplitude),
        .fund_valid   (fund_valid),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n_high;
        bit sq;
        int duty;
        int edges;
        bit fv;
        int fp;
        int amp;
        bit stall;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   last_n  = 0;

    function automatic void chk(string nm, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endfunction

    function automatic void clear_vecs();
        vecs.delete();
        last_n = 0;
    endfunction

    // Expected duty/edges follow from how each window is driven: high for the
    // first n clocks (or an 8/8 square wave), so at most one rising edge
    // lands at the window start unless the previous window ended high.
    function automatic void add(int n, bit sq, bit fv, int fp, int amp, bit st);
        vec_t v;
        v.n_high = n;
        v.sq     = sq;
        v.duty   = sq ? 2048 : (n >= WIN ? 4095 : n << (12 - W));
        v.edges  = sq ? WIN / 16 : ((n > 0 && last_n < WIN) ? 1 : 0);
        v.fv     = fv;
        v.fp     = fp;
        v.amp    = amp;
        v.stall  = st;
        last_n   = sq ? 0 : n;
        vecs.push_back(v);
    endfunction

    int   cyc;
    bit   first, pend;
    vec_t pe;

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc   = 0;
            first = 1'b1;
            pend  = 1'b0;
        end else begin
            cyc++;
            if (pend) begin
                chk("fund_valid", int'(fund_valid), int'(pe.fv));
                chk("fund_period", int'(fund_period), pe.fp);
                chk("amplitude", int'(amplitude), pe.amp);
                chk("stall", int'(stall), int'(pe.stall));
                pend = 1'b0;
            end else begin
                chk("fund_valid_idle", int'(fund_valid), 0);
            end
            if (duty_valid) begin
                if (sb.size() == 0) begin
                    chk("duty_valid_without_stimulus", int'(duty_valid), 0);
                end else begin
                    pe = sb.pop_front();
                    chk("duty", int'(duty), pe.duty);
                    chk("carrier_edges", int'(carrier_edges), pe.edges);
                    if (first) begin
                        chk("first_duty_valid_latency", cyc, WIN + 2);
                        first = 1'b0;
                    end
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic check_zero(string nm);
        chk({nm, "_duty"}, int'(duty), 0);
        chk({nm, "_duty_valid"}, int'(duty_valid), 0);
        chk({nm, "_carrier_edges"}, int'(carrier_edges), 0);
        chk({nm, "_fund_period"}, int'(fund_period), 0);
        chk({nm, "_amplitude"}, int'(amplitude), 0);
        chk({nm, "_fund_valid"}, int'(fund_valid), 0);
        chk({nm, "_stall"}, int'(stall), 0);
    endtask

    task automatic apply_reset(string nm);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero(nm);
        modulation = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_run();
        int i;
        sb.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        foreach (vecs[w]) begin
            sb.push_back(vecs[w]);
            for (int p = 0; p < WIN; p++) begin
                modulation = vecs[w].sq ? ((p % 16) < 8) : (p < vecs[w].n_high);
                @(negedge clk);
            end
        end
        modulation = 1'b0;
        i = 0;
        while ((sb.size() != 0 || pend) && i < 4 * WIN) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        modulation = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("por");

        // Held high: clamp to full scale, one initial edge only.
        clear_vecs();
        for (int w = 0; w < 3; w++) add(WIN, 1'b0, 1'b0, 0, 0, 1'b0);
        release_run();
        apply_reset("rst1");

        // 8/8 square wave: midscale, no crossing, stall once per_cnt saturates.
        clear_vecs();
        for (int w = 0; w < 32; w++) add(0, 1'b1, 1'b0, 0, 0, (w >= 30));
        release_run();
        apply_reset("rst2");

        // 3072/1024 alternation, then held low into stall, then resume.
        clear_vecs();
        for (int w = 0; w < 128; w++) begin
            int n, fp, amp;
            bit fv;
            if (w < 64)       n = ((w % 16) < 8) ? 192 : 64;
            else if (w < 104) n = 0;
            else              n = (((w - 104) % 16) < 8) ? 192 : 64;
            fv  = (w == 32 || w == 48 || w == 104 || w == 120);
            fp  = (w < 32) ? 0 : ((w >= 104 && w < 120) ? 31 : 16);
            amp = (w < 32) ? 0 : ((w >= 104 && w < 120) ? 1536 : 1024);
            add(n, 1'b0, fv, fp, amp, (w >= 78 && w < 104));
        end
        release_run();

        // Half a window of high input, then asynchronous reset mid-window.
        modulation = 1'b1;
        repeat (WIN / 2) @(negedge clk);
        apply_reset("mid_window_rst");
        clear_vecs();
        for (int w = 0; w < 2; w++) add(64, 1'b0, 1'b0, 0, 0, 1'b0);
        release_run();
        apply_reset("rst3");

        // Inside the hysteresis band: no state change, no fund_valid.
        clear_vecs();
        for (int w = 0; w < 8; w++) add((w % 2) ? 126 : 130, 1'b0, 1'b0, 0, 0, 1'b0);
        release_run();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
